// File: rtl/grid_pkg.sv
// Shared types for the Game-of-Life grid reader: grid geometry,
// row/grid vectors and the scanner state encoding.
package grid_pkg;

    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 8;
    localparam int GRID_W    = GRID_ROWS * GRID_COLS;
    localparam int ROW_W     = $clog2(GRID_ROWS);

    typedef logic [GRID_COLS-1:0] row_t;
    typedef logic [GRID_W-1:0]    grid_t;
    typedef logic [ROW_W-1:0]     row_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BLANK,
        DRIVE
    } scan_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// It stays at zero until the next load.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/grid_led_scanner.sv
// Double-buffered 8x8 LED matrix scanner for the Game-of-Life grid.
// New generations only reach the display buffer at frame boundaries.
module grid_led_scanner
    import grid_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  enable,
    input  grid_t grid,
    input  logic  grid_valid,
    output row_t  row_sel,
    output row_t  col_data,
    output logic  frame_start,
    output logic  frame_skipped
);

    localparam int TW = $clog2(max2(DWELL_CYCLES, BLANK_CYCLES) + 1);
    localparam logic [TW-1:0] DW_LD = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BL_LD =
        (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : '0;
    // With no blanking the inter-row gap collapses straight into DRIVE.
    localparam scan_state_t   GAP_ST = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
    localparam logic [TW-1:0] GAP_LD = (BLANK_CYCLES > 0) ? BL_LD : DW_LD;

    scan_state_t state_q, state_d;
    row_idx_t    row_q, row_d;
    grid_t       active_q, active_d;
    grid_t       pending_q, pending_d;
    logic        pend_vld_q, pend_vld_d;
    row_t        row_sel_q, row_sel_d;
    row_t        col_data_q, col_data_d;
    logic        fstart_q, fstart_d;
    logic        fskip_q, fskip_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    scan_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = LOAD;
            end
            LOAD: begin
                row_d    = '0;
                state_d  = GAP_ST;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            BLANK: begin
                if (tmr_done) begin
                    state_d  = DRIVE;
                    tmr_load = 1'b1;
                    tmr_val  = DW_LD;
                end
            end
            DRIVE: begin
                if (tmr_done) begin
                    if (row_q != row_idx_t'(GRID_ROWS - 1)) begin
                        row_d    = row_q + row_idx_t'(1);
                        state_d  = GAP_ST;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                    end else begin
                        state_d = enable ? LOAD : IDLE;
                    end
                end
            end
        endcase
    end

    // Newest generation wins; a strobe in LOAD bypasses the pending slot.
    always_comb begin
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        fskip_d    = 1'b0;
        if (grid_valid) begin
            if (state_q == LOAD) begin
                active_d   = grid;
                pend_vld_d = 1'b0;
            end else begin
                pending_d  = grid;
                pend_vld_d = 1'b1;
                fskip_d    = pend_vld_q;
            end
        end else if (state_q == LOAD && pend_vld_q) begin
            active_d   = pending_q;
            pend_vld_d = 1'b0;
        end
    end

    always_comb begin
        row_sel_d  = '0;
        col_data_d = '0;
        fstart_d   = (state_d == LOAD);
        if (state_d == DRIVE) begin
            row_sel_d  = row_t'(1) << row_d;
            col_data_d = active_d[row_d*GRID_COLS +: GRID_COLS];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            row_sel_q  <= '0;
            col_data_q <= '0;
            fstart_q   <= 1'b0;
            fskip_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            row_sel_q  <= row_sel_d;
            col_data_q <= col_data_d;
            fstart_q   <= fstart_d;
            fskip_q    <= fskip_d;
        end
    end

    assign row_sel       = row_sel_q;
    assign col_data      = col_data_q;
    assign frame_start   = fstart_q;
    assign frame_skipped = fskip_q;

endmodule

// File: doc/grid_led_scanner.md
Name: grid_led_scanner

Overview:
Reader end of the Game-of-Life grid interface. Consumes the 64-bit `grid` published by `main`, double-buffers it, and scans it row by row onto an 8x8 LED matrix. Outputs are a one-hot row select and 8 column lines, with blanking between rows. Buffers swap only at frame boundaries, so a new generation never tears mid-frame.

Parameters:
- DWELL_CYCLES, 1000, clk cycles each row is driven (>=1)
- BLANK_CYCLES, 4, clk cycles of all-off between rows (>=0; 0 skips BLANK)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- enable  input  1  scan enable; sampled only at frame boundaries
- grid  input  64  current generation; row r = grid[8r+7:8r], column c = bit 8r+c
- grid_valid  input  1  one-cycle strobe: grid holds a new generation
- row_sel  output  8  one-hot row drive; bit r = row r
- col_data  output  8  column drive for the selected row
- frame_start  output  1  one-cycle pulse in the LOAD cycle
- frame_skipped  output  1  one-cycle pulse when an unshown pending generation is overwritten

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release):
  - row_sel=0, col_data=0, frame_start=0, frame_skipped=0
  - state=IDLE, row=0, timer=0, pending=0, pending_valid=0, active=0
- State machine: IDLE -> LOAD -> (BLANK -> DRIVE) x8 -> LOAD or IDLE.
- IDLE:
  - outputs 0.
  - enable=1 at an edge -> LOAD.
- LOAD (exactly 1 cycle):
  - frame_start=1; row<=0.
  - If grid_valid=1 this cycle: active<=grid, pending_valid<=0 (newest wins, bypasses pending).
  - Else if pending_valid=1: active<=pending, pending_valid<=0.
  - Else: active unchanged.
  - Next state: BLANK, or DRIVE if BLANK_CYCLES=0.
- BLANK:
  - row_sel=0, col_data=0 for BLANK_CYCLES cycles, then DRIVE.
- DRIVE:
  - row_sel=1<<row, col_data=active[8row+7:8row] for DWELL_CYCLES cycles.
  - On the last cycle with row<7: row++, go to BLANK (or DRIVE if BLANK_CYCLES=0).
  - On the last cycle with row=7: go to LOAD if enable=1, else IDLE.
- Frame period: 1 + 8*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- grid_valid outside LOAD:
  - pending<=grid, pending_valid<=1.
  - If pending_valid was already 1, frame_skipped pulses next cycle; the last write wins.
- grid_valid in LOAD: never raises frame_skipped.
- enable=0 mid-frame: the frame completes all 8 rows, then IDLE with outputs 0. enable re-asserted before the row-7 end is not a drop.
- grid_valid in IDLE: captured into pending, shown at the next LOAD.
- Reset mid-DRIVE: outputs go to 0 immediately, with no clock edge; both buffers clear.
- Timer:
  - down-counter, width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1)
  - loaded with count-1 on state entry; expiry when it reaches 0.
- row_sel is never multi-hot. row_sel and col_data are both 0 outside DRIVE.

Decomposition:
- Package grid_pkg:
  - GRID_ROWS=8, GRID_COLS=8, GRID_W=64
  - typedef row_t (logic [7:0]); typedef grid_t (logic [63:0])
  - enum scan_state_t {IDLE, LOAD, BLANK, DRIVE}
- Sub-module scan_timer:
  - parameterised down-counter with load, load value, and done output
  - uses the same clk/reset

Test Plan (DWELL_CYCLES=3, BLANK_CYCLES=1, frame = 33 cycles):
1. Reset: hold reset=0 with enable=1, grid=all ones, grid_valid pulsed -> row_sel=0, col_data=0, both pulses 0. After release with enable=0 -> outputs stay 0.
2. Diagonal: grid=64'h8040201008040201 with grid_valid, then enable=1 -> frame_start once. Then for r=0..7: 1 blank cycle (0/0), then 3 cycles of row_sel=col_data=8'h01<<r. Next frame_start is 33 cycles after the first.
3. Tear-free update: mid-frame (row 3), grid=64'hFFFF_FFFF_FFFF_FFFF with grid_valid -> rows 3..7 still show the diagonal. After the next frame_start, every row shows col_data=8'hFF.
4. Skip detection: two grid_valid pulses in one frame (64'h1, then 64'h2) -> frame_skipped exactly once, one cycle after the second. The next frame's row 0 shows col_data=8'h02.
5. Enable drop: enable=0 during row 2 -> rows 2..7 complete, no further frame_start, outputs 0 in IDLE. Re-enable -> LOAD on the next cycle.
6. Async reset mid-DRIVE: reset=0 between clock edges -> row_sel/col_data=0 before the next edge. After release with enable=1 -> frame shows all zeros (buffers cleared).
